instr_encoder: RTL and testbench
================================

# instr_encoder

RISC-V RV32I instruction encoder with a valid/ready streaming interface. It packs per-field inputs (format, opcode, register addresses, funct fields, 32-bit immediate) into a 32-bit instruction word, range-checks the immediate, and tags each emitted word with a sequential instruction-memory word address. It sits in the test/program-loader path ahead of instruction memory, and is the write-side counterpart of the single-cycle core's instruction decoder: a legal encoded word decodes back to identical fields and immediate.

## Interface
- ADDR_W, 10: width of the output word address.
- BASE_ADDR, 0: word address loaded on reset and on `restart`.
- HALT_ON_ERR, 1: 1 = stop accepting after an illegal immediate until `restart`; 0 = drop the bad entry and continue.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- restart  in  1  synchronous; reloads the address, clears `err` and the count, returns to RUN.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept the bundle.
- fmt  in  instr_fmt_t (3)  FMT_R/I/S/B/U/J.
- opcode  in  7  copied to bits [6:0].
- rd_addr, rs1_addr, rs2_addr  in  5 each  register fields.
- funct3  in  3;  funct7  in  7.
- imm  in  32  signed byte-offset or value; U-type is the full upper value.
- out_valid  out  1  instruction word valid.
- out_ready  in  1  consumer accepts the word.
- instruction  out  32  encoded word.
- word_addr  out  ADDR_W  address paired with `instruction`.
- err  out  1  sticky illegal-immediate flag.
- count  out  16  number of words emitted since reset/restart; saturates at 0xFFFF.

## Operation
- Encoding:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}. For shifts, the caller places funct7 in imm[11:5].
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Fields not used by a format are ignored.
- Legality:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - R: always legal.
  - Undefined `fmt` value: illegal.
- States:
  - RUN: in_ready = !out_valid || out_ready.
  - HALT: in_ready=0 and out_valid drains normally.
- Accept (in_valid && in_ready), legal bundle: load the output register and set out_valid.
- Accept, illegal bundle: set `err`, do not load the output register, do not advance the address. If HALT_ON_ERR=1, go RUN→HALT.
- Emit (out_valid && out_ready): word_addr increments by 1 (wraps modulo 2^ADDR_W) and `count` increments.
- `restart` has priority over accept and emit in the same cycle. The word held in the output register is discarded (out_valid←0), word_addr←BASE_ADDR, count←0, err←0, state←RUN.
- Reset values: out_valid=0, instruction=0, word_addr=BASE_ADDR, err=0, count=0, state=RUN.

## Timing
- Latency: accept in cycle N gives out_valid/instruction/word_addr valid in cycle N+1.
- Throughput: 1 word/cycle while out_ready=1.
- While out_valid && !out_ready: instruction and word_addr are held stable and in_ready=0.
- Accept and emit in the same cycle: the new word replaces the old one, and the address increments exactly once.
- in_ready is combinational from out_valid, out_ready and state. It has no path from in_valid.
- err rises the cycle after the illegal accept.
- rst asserted mid-stream: outputs take their reset values immediately (asynchronously), and the in-flight word is lost.

## Structure
- Shared risc_pkg gains:
  - instr_fmt_t enum: FMT_R=0, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J.
  - Immediate range constants.
- The existing OPCODE_* constants are reused by benches.
- Sub-module imm_pack: purely combinational; (fmt, imm) → {bits[31:25], [24:20], [11:7] overrides, legal}.
- The top level holds the FSM, the output register, the address counter and the count.

## Test plan
- addi x1,x0,5 (FMT_I, opcode 0010011, rd=1, funct3=0, imm=5) → instruction 0x00500093 at word_addr=BASE_ADDR, count=1.
- sw x2,8(x1) (FMT_S, opcode 0100011, rs1=1, rs2=2, funct3=010, imm=8) → 0x0020A423. Then beq x0,x0,-4 (FMT_B, imm=-4) → 0xFE000EE3 at BASE_ADDR+1.
- jal x1,2048 (FMT_J, imm=0x800) → 0x001000EF. lui x5 (FMT_U, imm=0x12345000) → 0x123452B7.
- FMT_I with imm=2048 → err=1 next cycle, no word emitted, address unchanged. With HALT_ON_ERR=1, in_ready stays 0 until restart, then err=0 and word_addr=BASE_ADDR.
- Hold out_ready=0 for 3 cycles with in_valid=1 → instruction/word_addr stable and in_ready=0. Release → back-to-back words with consecutive addresses.
- Set word_addr to 2^ADDR_W-1, then emit 2 words → addresses wrap to 0. Assert rst mid-stream → out_valid=0 and word_addr=BASE_ADDR in the same cycle.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoder types: instruction formats, opcode constants, immediate ranges,
// and the field-override bundle produced by the immediate packer.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } instr_fmt_t;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

  localparam int IMM_I_MIN = -2048;
  localparam int IMM_I_MAX = 2047;
  localparam int IMM_B_MIN = -4096;
  localparam int IMM_B_MAX = 4094;
  localparam int IMM_J_MIN = -1048576;
  localparam int IMM_J_MAX = 1048574;

  localparam int IMM_I_SIGN_LSB = 11;
  localparam int IMM_B_SIGN_LSB = 12;
  localparam int IMM_J_SIGN_LSB = 20;

  typedef struct packed {
    logic       ov_31_25;
    logic [6:0] f31_25;
    logic       ov_24_20;
    logic [4:0] f24_20;
    logic       ov_19_12;
    logic [7:0] f19_12;
    logic       ov_11_7;
    logic [4:0] f11_7;
  } imm_fields_t;

  // True when every bit from lsb upward is a copy of the sign bit.
  function automatic logic sign_extends_from(input logic [31:0] v, input int lsb);
    logic [31:0] s;
    s = 32'($signed(v) >>> lsb);
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of the instruction encoder.
interface instr_encoder_if import instr_encoder_pkg::*; #(
  parameter int ADDR_W = 10
);

  logic              in_valid;
  logic              in_ready;
  instr_fmt_t        fmt;
  logic [6:0]        opcode;
  logic [4:0]        rd_addr;
  logic [4:0]        rs1_addr;
  logic [4:0]        rs2_addr;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [31:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       instruction;
  logic [ADDR_W-1:0] word_addr;
  logic              err;
  logic [15:0]       count;

  modport master (
    output in_valid, fmt, opcode, rd_addr, rs1_addr, rs2_addr, funct3, funct7, imm,
    output out_ready,
    input  in_ready, out_valid, instruction, word_addr, err, count
  );

  modport slave (
    input  in_valid, fmt, opcode, rd_addr, rs1_addr, rs2_addr, funct3, funct7, imm,
    input  out_ready,
    output in_ready, out_valid, instruction, word_addr, err, count
  );

endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Scatters the immediate into the instruction bit slots its format uses and
// reports whether the immediate is representable in that format.
module instr_encoder_imm_pack import instr_encoder_pkg::*; (
  input  instr_fmt_t  fmt,
  input  logic [31:0] imm,
  output imm_fields_t fields,
  output logic        legal
);

  always_comb begin
    fields = '0;
    legal  = 1'b0;
    case (fmt)
      FMT_R: begin
        legal = 1'b1;
      end
      FMT_I: begin
        fields.ov_31_25 = 1'b1;
        fields.f31_25   = imm[11:5];
        fields.ov_24_20 = 1'b1;
        fields.f24_20   = imm[4:0];
        legal           = sign_extends_from(imm, IMM_I_SIGN_LSB);
      end
      FMT_S: begin
        fields.ov_31_25 = 1'b1;
        fields.f31_25   = imm[11:5];
        fields.ov_11_7  = 1'b1;
        fields.f11_7    = imm[4:0];
        legal           = sign_extends_from(imm, IMM_I_SIGN_LSB);
      end
      FMT_B: begin
        fields.ov_31_25 = 1'b1;
        fields.f31_25   = {imm[12], imm[10:5]};
        fields.ov_11_7  = 1'b1;
        fields.f11_7    = {imm[4:1], imm[11]};
        legal           = sign_extends_from(imm, IMM_B_SIGN_LSB) && !imm[0];
      end
      FMT_U: begin
        fields.ov_31_25 = 1'b1;
        fields.f31_25   = imm[31:25];
        fields.ov_24_20 = 1'b1;
        fields.f24_20   = imm[24:20];
        fields.ov_19_12 = 1'b1;
        fields.f19_12   = imm[19:12];
        legal           = (imm[11:0] == 12'd0);
      end
      // J scrambles imm[20|10:1|11|19:12] across the whole upper 20 bits.
      FMT_J: begin
        fields.ov_31_25 = 1'b1;
        fields.f31_25   = {imm[20], imm[10:5]};
        fields.ov_24_20 = 1'b1;
        fields.f24_20   = {imm[4:1], imm[11]};
        fields.ov_19_12 = 1'b1;
        fields.f19_12   = imm[19:12];
        legal           = sign_extends_from(imm, IMM_J_SIGN_LSB) && !imm[0];
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs field bundles into 32-bit words, tags each with a
// sequential instruction-memory word address, and flags out-of-range immediates.
module instr_encoder import instr_encoder_pkg::*; #(
  parameter int ADDR_W      = 10,
  parameter int BASE_ADDR   = 0,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            restart,
  instr_encoder_if.slave  bus
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]        state_q;
  logic              out_valid_q;
  logic [31:0]       instruction_q;
  logic [ADDR_W-1:0] word_addr_q;
  logic              err_q;
  logic [15:0]       count_q;

  imm_fields_t fields;
  logic        legal;
  logic [31:0] word;
  logic        accept;
  logic        emit;

  instr_encoder_imm_pack u_imm_pack (
    .fmt    (bus.fmt),
    .imm    (bus.imm),
    .fields (fields),
    .legal  (legal)
  );

  // Each slot takes the immediate bits when the format claims it, else the register/funct field.
  assign word = {
    fields.ov_31_25 ? fields.f31_25 : bus.funct7,
    fields.ov_24_20 ? fields.f24_20 : bus.rs2_addr,
    fields.ov_19_12 ? fields.f19_12 : {bus.rs1_addr, bus.funct3},
    fields.ov_11_7  ? fields.f11_7  : bus.rd_addr,
    bus.opcode
  };

  assign bus.in_ready = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign emit         = out_valid_q && bus.out_ready;

  // Output register, address counter, emit count and halt state. An emit and a legal
  // accept in the same cycle replace the word while advancing the address once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      out_valid_q   <= 1'b0;
      instruction_q <= '0;
      word_addr_q   <= BASE;
      err_q         <= 1'b0;
      count_q       <= '0;
    end else if (restart) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      word_addr_q <= BASE;
      err_q       <= 1'b0;
      count_q     <= '0;
    end else begin
      if (emit) begin
        out_valid_q <= 1'b0;
        word_addr_q <= word_addr_q + 1'b1;
        if (count_q != 16'hFFFF) begin
          count_q <= count_q + 16'd1;
        end
      end
      if (accept) begin
        if (legal) begin
          out_valid_q   <= 1'b1;
          instruction_q <= word;
        end else begin
          err_q <= 1'b1;
          if (HALT_ON_ERR) begin
            state_q <= ST_HALT;
          end
        end
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.instruction = instruction_q;
  assign bus.word_addr   = word_addr_q;
  assign bus.err         = err_q;
  assign bus.count       = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized bench for instr_encoder against a cycle-level reference model
// whose encodings and legality come from the format rules and integer immediate ranges.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int ADDR_W      = 10;
  localparam int BASE_ADDR   = 0;
  localparam bit HALT_ON_ERR = 1'b1;
  localparam int ADDR_MOD    = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  logic restart;

  int checks = 0;
  int errors = 0;

  logic        m_ov;
  logic [31:0] m_instr;
  int          m_addr;
  int          m_count;
  logic        m_err;
  logic        m_halt;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE_ADDR),
    .HALT_ON_ERR (HALT_ON_ERR)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ov    = 1'b0;
    m_instr = '0;
    m_addr  = BASE_ADDR;
    m_count = 0;
    m_err   = 1'b0;
    m_halt  = 1'b0;
  endtask

  // Reference encoding built from shifted field values and signed immediate ranges.
  task automatic model_encode(output logic [31:0] w, output bit ok);
    logic [31:0] imm;
    logic [31:0] regs;
    logic [31:0] low;
    int          s;
    imm  = bus.imm;
    s    = bus.imm;
    regs = (32'(bus.rs2_addr) << 20) | (32'(bus.rs1_addr) << 15) | (32'(bus.funct3) << 12);
    low  = (32'(bus.rd_addr) << 7) | 32'(bus.opcode);
    w    = '0;
    ok   = 1'b0;
    case (bus.fmt)
      FMT_R: begin
        ok = 1'b1;
        w  = (32'(bus.funct7) << 25) | regs | low;
      end
      FMT_I: begin
        ok = (s >= IMM_I_MIN) && (s <= IMM_I_MAX);
        w  = ((imm % 4096) << 20) | (32'(bus.rs1_addr) << 15) | (32'(bus.funct3) << 12) | low;
      end
      FMT_S: begin
        ok = (s >= IMM_I_MIN) && (s <= IMM_I_MAX);
        w  = (((imm / 32) % 128) << 25) | regs | ((imm % 32) << 7) | 32'(bus.opcode);
      end
      FMT_B: begin
        ok = (s >= IMM_B_MIN) && (s <= IMM_B_MAX) && (s % 2 == 0);
        w  = (((imm / 4096) % 2) << 31) | (((imm / 32) % 64) << 25) | regs
           | (((imm / 2) % 16) << 8) | (((imm / 2048) % 2) << 7) | 32'(bus.opcode);
      end
      FMT_U: begin
        ok = (imm % 4096) == 0;
        w  = (imm - (imm % 4096)) | low;
      end
      FMT_J: begin
        ok = (s >= IMM_J_MIN) && (s <= IMM_J_MAX) && (s % 2 == 0);
        w  = (((imm / 1048576) % 2) << 31) | (((imm / 2) % 1024) << 21)
           | (((imm / 2048) % 2) << 20) | (((imm / 4096) % 256) << 12) | low;
      end
      default: begin
        ok = 1'b0;
      end
    endcase
  endtask

  task automatic apply_stimulus(input instr_fmt_t f, input logic [6:0] op, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm);
    bus.fmt      = f;
    bus.opcode   = op;
    bus.rd_addr  = rd;
    bus.rs1_addr = rs1;
    bus.rs2_addr = rs2;
    bus.funct3   = f3;
    bus.funct7   = f7;
    bus.imm      = imm;
  endtask

  task automatic rand_bundle(input bit legal_only);
    int          bnd[10] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, 1048574, -1048576, 1048576};
    logic [2:0]  f;
    logic [31:0] imm;
    int          v;
    f = legal_only ? 3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
    case (f)
      3'd1, 3'd2: v = int'($urandom_range(0, 4095)) - 2048;
      3'd3:       v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      3'd4:       v = int'($urandom & 32'hFFFF_F000);
      3'd5:       v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      default:    v = int'($urandom);
    endcase
    imm = v;
    if (!legal_only && $urandom_range(0, 3) == 0) begin
      imm = ($urandom_range(0, 1) == 0) ? $urandom : bnd[$urandom_range(0, 9)];
    end
    apply_stimulus(instr_fmt_t'(f), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   3'($urandom), 7'($urandom), imm);
  endtask

  // One clock: compare DUT against the model mid-cycle, then advance the model past the edge.
  task automatic run_cycle();
    bit          exp_ready;
    bit          acc;
    bit          emt;
    bit          ok;
    bit          rs;
    logic [31:0] w;
    #2;
    exp_ready = !m_halt && (!m_ov || bus.out_ready);
    check_output("in_ready", 32'(bus.in_ready), 32'(exp_ready));
    check_output("out_valid", 32'(bus.out_valid), 32'(m_ov));
    if (m_ov) check_output("instruction", bus.instruction, m_instr);
    check_output("word_addr", 32'(bus.word_addr), m_addr);
    check_output("err", 32'(bus.err), 32'(m_err));
    check_output("count", 32'(bus.count), m_count);
    acc = bus.in_valid && exp_ready;
    emt = m_ov && bus.out_ready;
    rs  = restart;
    model_encode(w, ok);
    @(posedge clk);
    #1;
    if (rs) begin
      m_ov    = 1'b0;
      m_addr  = BASE_ADDR;
      m_count = 0;
      m_err   = 1'b0;
      m_halt  = 1'b0;
    end else begin
      if (emt) begin
        m_ov   = 1'b0;
        m_addr = (m_addr + 1) % ADDR_MOD;
        if (m_count < 65535) m_count++;
      end
      if (acc) begin
        if (ok) begin
          m_ov    = 1'b1;
          m_instr = w;
        end else begin
          m_err = 1'b1;
          if (HALT_ON_ERR) m_halt = 1'b1;
        end
      end
    end
  endtask

  initial begin
    rst           = 1'b1;
    restart       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    apply_stimulus(FMT_R, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check_output("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("rst_instruction", bus.instruction, 32'd0);
    check_output("rst_word_addr", 32'(bus.word_addr), BASE_ADDR);
    check_output("rst_err", 32'(bus.err), 32'd0);
    check_output("rst_count", 32'(bus.count), 32'd0);
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // addi x1,x0,5 held, then drained
    apply_stimulus(FMT_I, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    bus.in_valid = 1'b1;
    run_cycle();
    bus.in_valid = 1'b0;
    check_output("addi_word", bus.instruction, 32'h0050_0093);
    check_output("addi_addr", 32'(bus.word_addr), BASE_ADDR);
    bus.out_ready = 1'b1;
    run_cycle();
    check_output("addi_count", 32'(bus.count), 32'd1);

    restart = 1'b1;
    run_cycle();
    restart = 1'b0;

    // sw, beq, jal, lui back to back
    bus.in_valid = 1'b1;
    apply_stimulus(FMT_S, OPCODE_STORE, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8);
    run_cycle();
    check_output("sw_word", bus.instruction, 32'h0020_A423);
    check_output("sw_addr", 32'(bus.word_addr), BASE_ADDR);
    apply_stimulus(FMT_B, OPCODE_BRANCH, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, -32'sd4);
    run_cycle();
    check_output("beq_word", bus.instruction, 32'hFE00_0EE3);
    check_output("beq_addr", 32'(bus.word_addr), BASE_ADDR + 1);
    apply_stimulus(FMT_J, OPCODE_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800);
    run_cycle();
    check_output("jal_word", bus.instruction, 32'h0010_00EF);
    apply_stimulus(FMT_U, OPCODE_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    run_cycle();
    check_output("lui_word", bus.instruction, 32'h1234_52B7);
    check_output("lui_addr", 32'(bus.word_addr), BASE_ADDR + 3);
    bus.in_valid = 1'b0;
    run_cycle();

    // out-of-range I immediate halts until restart
    bus.in_valid = 1'b1;
    apply_stimulus(FMT_I, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    run_cycle();
    check_output("illegal_err", 32'(bus.err), 32'd1);
    check_output("illegal_no_word", 32'(bus.out_valid), 32'd0);
    check_output("illegal_addr", 32'(bus.word_addr), BASE_ADDR + 4);
    apply_stimulus(FMT_I, OPCODE_OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    repeat (3) run_cycle();
    check_output("halt_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    restart      = 1'b1;
    run_cycle();
    restart = 1'b0;
    check_output("restart_err", 32'(bus.err), 32'd0);
    check_output("restart_addr", 32'(bus.word_addr), BASE_ADDR);
    check_output("restart_in_ready", 32'(bus.in_ready), 32'd1);

    // back-pressure for 3 cycles, then release
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    run_cycle();
    for (int i = 0; i < 3; i++) begin
      rand_bundle(1'b1);
      run_cycle();
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rand_bundle(1'b1);
      run_cycle();
    end

    // random formats, immediates, handshakes and restarts
    for (int i = 0; i < 400; i++) begin
      restart       = m_halt ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
      bus.in_valid  = $urandom_range(0, 2) != 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      rand_bundle(1'b0);
      run_cycle();
    end
    bus.in_valid = 1'b0;
    restart      = 1'b1;
    run_cycle();
    restart = 1'b0;

    // long legal stream so the address wraps past 2^ADDR_W-1
    for (int i = 0; i < 6000 && m_count < ADDR_MOD + 1; i++) begin
      bus.in_valid  = $urandom_range(0, 3) != 0;
      bus.out_ready = $urandom_range(0, 3) != 0;
      rand_bundle(1'b1);
      run_cycle();
    end
    check_output("wrap_count", 32'(bus.count), ADDR_MOD + 1);
    check_output("wrap_addr", 32'(bus.word_addr), (BASE_ADDR + 1) % ADDR_MOD);

    // asynchronous reset with a word in flight
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    rand_bundle(1'b1);
    run_cycle();
    check_output("inflight_valid", 32'(bus.out_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_output("async_out_valid", 32'(bus.out_valid), 32'd0);
    check_output("async_word_addr", 32'(bus.word_addr), BASE_ADDR);
    check_output("async_count", 32'(bus.count), 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
